iob_cache_be_mem: RTL and testbench



---
 rtl/iob_cache_be_mem_pkg.sv | 28 ++
 rtl/iob_cache_be_mem_ram.sv | 53 +++++
 rtl/iob_cache_be_mem.sv | 160 ++++++++++++++++
 tb/tb_iob_cache_be_mem.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_cache_be_mem_pkg.sv
// Shared definitions for the cache back-end memory responder: FSM state
// encodings, LFSR constants for the optional random-latency mode, and the
// byte-offset width derivation macro.
`ifndef IOB_CACHE_BE_MEM_PKG_SV
`define IOB_CACHE_BE_MEM_PKG_SV

// Number of byte-offset address bits for a data word of width data_w.
`define IOB_CACHE_BE_MEM_NBYTES_W(data_w) ($clog2((data_w) / 8))

package iob_cache_be_mem_pkg;

    typedef enum logic [1:0] {
        IOB_CACHE_BE_MEM_IDLE = 2'd0,
        IOB_CACHE_BE_MEM_WAIT = 2'd1,
        IOB_CACHE_BE_MEM_RESP = 2'd2
    } state_t;

    // Fibonacci LFSR x^8+x^6+x^5+x^4+1, shifting left; taps on bits 7,5,4,3.
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

`endif

// File: rtl/iob_cache_be_mem_ram.sv
// Single-port synchronous RAM with per-byte write enables and a registered
// read port. The read register only updates on read accesses, so the last
// read word is held through writes and idle cycles.
module iob_cache_be_mem_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [DATA_W/8-1:0]   wstrb_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [DATA_W-1:0]     rdata_o
);

    localparam int NBYTES = DATA_W / 8;

    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // Read data register: capture the addressed word on read accesses only.
    always_comb begin
        rdata_d = rdata_q;
        if (en_i && (wstrb_i == '0)) begin
            rdata_d = mem[addr_i];
        end
    end

    // Read data register with reset to zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    // Byte-granular write port; contents are never reset.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (wstrb_i[b]) begin
                    mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/iob_cache_be_mem.sv
// Back-end memory responder for the cache memory-side port. Accepts one
// request at a time, waits a number of cycles, accesses the RAM and pulses
// be_ack for one cycle.
// Optional feature macro: IOB_CACHE_BE_MEM_RANDLAT_EN adds a pseudo-random
// 0..3 extra wait states drawn from an 8-bit LFSR.
module iob_cache_be_mem #(
    parameter int BE_ADDR_W  = 24,
    parameter int BE_DATA_W  = 32,
    parameter int MEM_ADDR_W = 12,
    parameter int LATENCY    = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   be_req,
    input  logic [BE_ADDR_W-1:0]   be_addr,
    input  logic [BE_DATA_W-1:0]   be_wdata,
    input  logic [BE_DATA_W/8-1:0] be_wstrb,
    output logic [BE_DATA_W-1:0]   be_rdata,
    output logic                   be_ack
);

    import iob_cache_be_mem_pkg::*;

    localparam int NBYTES   = BE_DATA_W / 8;
    localparam int NBYTES_W = `IOB_CACHE_BE_MEM_NBYTES_W(BE_DATA_W);
    localparam int CNT_W    = $clog2(LATENCY + 4) + 1;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [MEM_ADDR_W-1:0]   addr_q, addr_d;
    logic [BE_DATA_W-1:0]    wdata_q, wdata_d;
    logic [NBYTES-1:0]       wstrb_q, wstrb_d;
    logic [CNT_W-1:0]        wait_total;
    logic [MEM_ADDR_W-1:0]   req_idx;
    logic                    ram_access;
    logic                    ram_en;
    logic [MEM_ADDR_W-1:0]   ram_addr;
    logic [BE_DATA_W-1:0]    ram_wdata;
    logic [NBYTES-1:0]       ram_wstrb;
    logic                    addr_unused;

    // Only the word index bits select a RAM word; the rest alias.
    assign req_idx     = be_addr[MEM_ADDR_W+NBYTES_W-1:NBYTES_W];
    assign addr_unused = ^be_addr;

`ifdef IOB_CACHE_BE_MEM_RANDLAT_EN
    logic [7:0] lfsr_q, lfsr_d;

    assign wait_total = CNT_W'(LATENCY) + CNT_W'(lfsr_q[1:0]);

    // LFSR advances once per accepted request, after its value was used.
    always_comb begin
        lfsr_d = lfsr_q;
        if ((state_q == IOB_CACHE_BE_MEM_IDLE) && be_req) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    // LFSR register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign wait_total = CNT_W'(LATENCY);
`endif

    // Next-state logic, wait counter and request latching.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        ram_access = 1'b0;
        case (state_q)
            IOB_CACHE_BE_MEM_IDLE: begin
                if (be_req) begin
                    addr_d  = req_idx;
                    wdata_d = be_wdata;
                    wstrb_d = be_wstrb;
                    cnt_d   = wait_total;
                    if (wait_total == '0) begin
                        ram_access = 1'b1;
                        state_d    = IOB_CACHE_BE_MEM_RESP;
                    end else begin
                        state_d = IOB_CACHE_BE_MEM_WAIT;
                    end
                end
            end
            IOB_CACHE_BE_MEM_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    ram_access = 1'b1;
                    state_d    = IOB_CACHE_BE_MEM_RESP;
                end
            end
            IOB_CACHE_BE_MEM_RESP: begin
                state_d = IOB_CACHE_BE_MEM_IDLE;
            end
            default: begin
                state_d = IOB_CACHE_BE_MEM_IDLE;
            end
        endcase
    end

    // Zero-wait accesses happen on the accepting edge, so they use the live
    // inputs; all later accesses use the latched operands.
    always_comb begin
        if (state_q == IOB_CACHE_BE_MEM_IDLE) begin
            ram_addr  = req_idx;
            ram_wdata = be_wdata;
            ram_wstrb = be_wstrb;
        end else begin
            ram_addr  = addr_q;
            ram_wdata = wdata_q;
            ram_wstrb = wstrb_q;
        end
    end

    // A reset edge must never commit a pending access.
    assign ram_en = ram_access & ~rst_i;

    // Control registers: state and wait counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IOB_CACHE_BE_MEM_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Latched request operands; no reset needed.
    always_ff @(posedge clk_i) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        wstrb_q <= wstrb_d;
    end

    iob_cache_be_mem_ram #(
        .DATA_W (BE_DATA_W),
        .ADDR_W (MEM_ADDR_W)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (ram_en),
        .wstrb_i (ram_wstrb),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (be_rdata)
    );

    assign be_ack = (state_q == IOB_CACHE_BE_MEM_RESP);

endmodule

// File: tb/tb_iob_cache_be_mem.sv
// Scoreboard bench for iob_cache_be_mem: the stimulus process drives
// requests and queues the expected ack cycle and read data from a
// word-array reference model; a monitor pops and checks on every ack.
module tb_iob_cache_be_mem;

    localparam int LAT = 2;
    localparam int MAW = 4;
    localparam int NWORDS = 1 << MAW;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        be_req;
    logic [23:0] be_addr;
    logic [31:0] be_wdata;
    logic [3:0]  be_wstrb;
    logic [31:0] be_rdata;
    logic        be_ack;

    iob_cache_be_mem #(
        .BE_ADDR_W  (24),
        .BE_DATA_W  (32),
        .MEM_ADDR_W (MAW),
        .LATENCY    (LAT)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .be_req   (be_req),
        .be_addr  (be_addr),
        .be_wdata (be_wdata),
        .be_wstrb (be_wstrb),
        .be_rdata (be_rdata),
        .be_ack   (be_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          ack_edge;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;

    // Reference model state
    logic [31:0] mdl_mem [NWORDS];
    logic [31:0] mdl_last;
    logic [7:0]  mdl_lfsr;
    int          next_free;

    function automatic int word_of(input logic [23:0] a);
        return int'((a / 24'd4) % 24'(NWORDS));
    endfunction

    function automatic logic [31:0] strobe_mask(input logic [3:0] s);
        logic [31:0] m;
        m = 32'h0;
        for (int i = 0; i < 4; i++)
            if (s[i]) m = m | (32'hFF << (8 * i));
        return m;
    endfunction

    // Total wait for the next accepted request.
    function automatic int model_wait();
        int w;
        w = LAT;
`ifdef IOB_CACHE_BE_MEM_RANDLAT_EN
        w = w + int'(mdl_lfsr[1:0]);
        mdl_lfsr = {mdl_lfsr[6:0], mdl_lfsr[7] ^ mdl_lfsr[5] ^ mdl_lfsr[4] ^ mdl_lfsr[3]};
`endif
        return w;
    endfunction

    task automatic model_reset();
        mdl_lfsr  = 8'hA5;
        mdl_last  = 32'h0;
        next_free = 0;
    endtask

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    // One transfer. Called just after an active edge; returns just after an
    // active edge with be_req either held (gap 0) or dropped for gap cycles.
    task automatic xfer(input logic [23:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int gap, input bit scramble);
        int          k;
        int          w;
        int          idx;
        int          n;
        exp_t        e;
        logic [31:0] m;
        be_req   = 1'b1;
        be_addr  = a;
        be_wdata = d;
        be_wstrb = s;
        k = (cyc + 1 > next_free) ? cyc + 1 : next_free;
        w = model_wait();
        idx = word_of(a);
        if (s != 4'h0) begin
            m = strobe_mask(s);
            mdl_mem[idx] = (mdl_mem[idx] & ~m) | (d & m);
        end else begin
            mdl_last = mdl_mem[idx];
        end
        e.ack_edge = k + w;
        e.rdata    = mdl_last;
        sb.push_back(e);
        next_free = k + w + 2;
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
        if (scramble) begin
            be_addr  = 24'($urandom);
            be_wdata = $urandom;
            be_wstrb = 4'($urandom);
        end
        n = 0;
        forever begin
            @(negedge clk);
            if (be_ack) break;
            n++;
            if (n > 40) begin
                errors++;
                $display("FAIL ack_timeout: no ack within 40 cycles, required ack at edge %0d", e.ack_edge);
                finish_sim();
            end
        end
        @(posedge clk);
        #1;
        if (gap > 0) begin
            be_req = 1'b0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    // Monitor: every ack must match the head of the scoreboard.
    initial begin
        exp_t e;
        logic prev_ack;
        prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (be_ack === 1'b1) begin
                checks++;
                if (prev_ack) begin
                    errors++;
                    $display("FAIL ack_spacing: ack high in consecutive cycles at edge %0d", cyc);
                end
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: ack at edge %0d with no request outstanding", cyc);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (cyc != e.ack_edge) begin
                        errors++;
                        $display("FAIL ack_timing: ack at edge %0d, required edge %0d", cyc, e.ack_edge);
                    end
                    checks++;
                    if (be_rdata !== e.rdata) begin
                        errors++;
                        $display("FAIL rdata: got %h, required %h (edge %0d)", be_rdata, e.rdata, cyc);
                    end
                end
            end
            prev_ack = be_ack;
        end
    end

    task automatic check_idle_outputs(input string name);
        checks++;
        if (be_ack !== 1'b0 || be_rdata !== 32'h0) begin
            errors++;
            $display("FAIL %s: ack=%b rdata=%h, required ack=0 rdata=00000000", name, be_ack, be_rdata);
        end
    endtask

    initial begin
        int k;
        int w;
        // Reset held with a pending request.
        rst_i    = 1'b1;
        be_req   = 1'b1;
        be_addr  = 24'h0;
        be_wdata = 32'h0;
        be_wstrb = 4'h0;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_idle_outputs("reset_outputs");
        end
        rst_i  = 1'b0;
        be_req = 1'b0;
        @(posedge clk);
        #1;

        // Fill every word, with random upper address bits (aliasing).
        for (int i = 0; i < NWORDS; i++)
            xfer({12'($urandom), 6'($urandom), 6'(i * 4)} & 24'hFFFFFC,
                 $urandom, 4'hF, $urandom_range(0, 1), 1'b0);

        // Full write then read.
        xfer(24'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0);
        xfer(24'h10, 32'h0, 4'h0, 1, 1'b0);

        // Partial strobe merge.
        xfer(24'h20, 32'h11223344, 4'hF, 0, 1'b0);
        xfer(24'h20, 32'hAABBCCDD, 4'h5, 0, 1'b0);
        xfer(24'h20, 32'h0, 4'h0, 2, 1'b0);

        // Line read with be_req held continuously.
        for (int i = 0; i < 4; i++)
            xfer(24'(i * 4), 32'(i + 1), 4'hF, 0, 1'b0);
        for (int i = 0; i < 4; i++)
            xfer(24'(i * 4), 32'h0, 4'h0, (i == 3) ? 2 : 0, 1'b0);

        // Reset during the first WAIT cycle of a write.
        be_req   = 1'b1;
        be_addr  = 24'h30;
        be_wdata = 32'h55;
        be_wstrb = 4'hF;
        k = (cyc + 1 > next_free) ? cyc + 1 : next_free;
        w = model_wait();
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
        rst_i  = 1'b1;
        be_req = 1'b0;
        @(negedge clk);
        checks++;
        if (be_ack !== 1'b0) begin
            errors++;
            $display("FAIL midwait_ack: ack=%b, required 0 (wait %0d)", be_ack, w);
        end
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        model_reset();
        @(negedge clk);
        check_idle_outputs("midwait_reset_outputs");
        @(posedge clk);
        #1;
        xfer(24'h30, 32'h0, 4'h0, 1, 1'b0);

        // Address aliasing: byte 0x40 wraps onto word 0.
        xfer(24'h40, 32'h99, 4'hF, 0, 1'b0);
        xfer(24'h0, 32'h0, 4'h0, 1, 1'b0);

        // Randomized traffic with operand scrambling after acceptance.
        for (int i = 0; i < 80; i++) begin
            logic [3:0] s;
            s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            xfer(24'($urandom) & 24'hFFFFFC, $urandom, s,
                 ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3),
                 1'($urandom_range(0, 1)));
        end
        be_req = 1'b0;

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
        end
        finish_sim();
    end

endmodule
